presence_detector: RTL
======================

PRESENCE_DETECTOR -- requirements
Module: presence_detector

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  TRIG_CYCLES       32'd500        trigger pulse width (10 us at 50 MHz)
  PERIOD_CYCLES     32'd3000000    measurement period (60 ms)
  ECHO_TIMEOUT      32'd1900000    max echo wait and max echo width (38 ms)
  THRESHOLD_CYCLES  32'd290000     echo width below which the target is "near" (~100 cm)
  CONFIRM_COUNT     2'd3           consecutive near results to assert presence
  RELEASE_COUNT     2'd3           consecutive far/timeout results to deassert presence
REQ-002 Ports (name, direction, width, meaning), one per line:
  in_clock              input   1   system clock, 50 MHz, rising edge
  in_reset              input   1   reset, asynchronous, active-high
  in_echo               input   1   ultrasonic sensor echo, asynchronous to in_clock
  out_trigger           output  1   ultrasonic sensor trigger pulse
  out_presence_signal   output  1   filtered presence, drives the welcomer control presence input
  out_echo_width        output  32  last measured echo width in clock cycles
  out_measure_valid     output  1   one-cycle strobe: new result on out_echo_width
  out_timeout_error     output  1   one-cycle strobe coincident with out_measure_valid when the result is a timeout
REQ-003 One clock domain (in_clock); reset is asynchronous and active-high (in_reset).

Function
REQ-004 in_echo SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (echo_s); 2-cycle input latency.
REQ-005 FSM states: IDLE, TRIGGER, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-006 Period counter: loaded with PERIOD_CYCLES-1 on each entry to TRIGGER, decrements to 0 and holds; measurement start-to-start spacing is exactly PERIOD_CYCLES cycles unless REQ-012 extends it.
REQ-007 IDLE: if the period counter is 0, go to TRIGGER next cycle (after reset: first trigger at first clock edge after in_reset falls).
REQ-008 TRIGGER: out_trigger = 1 for exactly TRIG_CYCLES cycles, then 0; go to WAIT_ECHO.
REQ-009 WAIT_ECHO: on echo_s = 1 go to MEASURE with width counter = 1; if ECHO_TIMEOUT cycles elapse with echo_s = 0, complete with a timeout.
REQ-010 MEASURE: width counter +1 per cycle while echo_s = 1; on echo_s = 0 complete with width = counter value; if counter reaches ECHO_TIMEOUT, complete with a timeout (counter saturates, no wrap).
REQ-011 Completion, same cycle: out_echo_width <= width (ECHO_TIMEOUT on a timeout), out_measure_valid = 1 for one cycle, out_timeout_error = 1 for that cycle only on a timeout; go to HOLDOFF.
REQ-012 HOLDOFF: go to TRIGGER when the period counter is 0 AND echo_s = 0; if echo is still high, wait for it to go low.
REQ-013 Classification: near = (not timeout) AND width < THRESHOLD_CYCLES; width == THRESHOLD_CYCLES is far.
REQ-014 Filter: 2-bit saturating near-run and far-run counters; near clears far-run, and far/timeout clears near-run; counters update only on completion.
REQ-015 out_presence_signal rises on the completion where near-run reaches CONFIRM_COUNT; falls on the completion where far-run reaches RELEASE_COUNT; otherwise it holds. It changes only on the same cycle as out_measure_valid.
REQ-016 An echo_s high during TRIGGER or IDLE is ignored; it is not measured.

Reset
REQ-017 While in_reset = 1: state = IDLE; out_trigger, out_presence_signal, out_measure_valid, out_timeout_error = 0; out_echo_width = 0; all counters and synchronizer flops = 0.
REQ-018 Reset mid-pulse or mid-measure SHALL drop out_trigger immediately (asynchronous), discard the partial result, and emit no out_measure_valid.

Verification (bench params: TRIG=5, PERIOD=200, TIMEOUT=100, THRESHOLD=40, CONFIRM=RELEASE=3)
REQ-019 Release reset, hold in_echo = 0 -> out_trigger high 5 cycles starting at the first edge; a timeout strobe each period; out_echo_width = 100; presence stays 0.
REQ-020 Echo high for 30 cycles after each trigger, 3 periods -> 3 strobes with width 30; presence rises on the 3rd strobe cycle, not before.
REQ-021 Presence = 1, then echo width 40 (boundary) for 3 periods -> presence falls on the 3rd strobe; a near, far, near, far pattern -> presence never changes.
REQ-022 Echo held high for 150 cycles -> timeout strobe at width 100; the next trigger waits until echo falls (period is extended).
REQ-023 Assert in_reset during MEASURE -> out_trigger and all outputs are 0 immediately; no strobe; after release, the first trigger is on the next edge.
REQ-024 Echo glitch during TRIGGER -> ignored; the measurement starts only on the echo after the trigger ends.

Source files
------------

// File: rtl/presence_detector.sv
// Ultrasonic presence detector: periodic trigger, echo width measurement,
// timeout detection and a near/far run-length filter on the result.
module presence_detector #(
    parameter logic [31:0] TRIG_CYCLES      = 32'd500,
    parameter logic [31:0] PERIOD_CYCLES    = 32'd3000000,
    parameter logic [31:0] ECHO_TIMEOUT     = 32'd1900000,
    parameter logic [31:0] THRESHOLD_CYCLES = 32'd290000,
    parameter logic [1:0]  CONFIRM_COUNT    = 2'd3,
    parameter logic [1:0]  RELEASE_COUNT    = 2'd3
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_echo,
    output logic        out_trigger,
    output logic        out_presence_signal,
    output logic [31:0] out_echo_width,
    output logic        out_measure_valid,
    output logic        out_timeout_error
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned RUN_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIGGER   = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               echo_meta_q, echo_s_q;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   echo_width_q, echo_width_d;
    logic [RUN_W-1:0]   near_run_q, near_run_d;
    logic [RUN_W-1:0]   far_run_q, far_run_d;
    logic               trigger_q, trigger_d;
    logic               presence_q, presence_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               trig_last_c;
    logic               wait_to_c;
    logic               meas_to_c;
    logic               meas_ok_c;
    logic               done_c;
    logic               near_c;

    // Two-flop synchronizer for the asynchronous echo input
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= in_echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    // State register
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Measurement events: end of trigger pulse, timeouts and normal completion
    always_comb begin
        trig_last_c = (trig_cnt_q >= TRIG_CYCLES - 32'd1);
        wait_to_c   = (state_q == ST_WAIT_ECHO) && !echo_s_q &&
                      (width_q >= ECHO_TIMEOUT - 32'd1);
        meas_to_c   = (state_q == ST_MEASURE) && echo_s_q &&
                      (width_q >= ECHO_TIMEOUT - 32'd1);
        meas_ok_c   = (state_q == ST_MEASURE) && !echo_s_q;
        done_c      = wait_to_c || meas_to_c || meas_ok_c;
        near_c      = meas_ok_c && (width_q < THRESHOLD_CYCLES);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (period_q == '0) state_d = ST_TRIGGER;
            end
            ST_TRIGGER: begin
                if (trig_last_c) state_d = ST_WAIT_ECHO;
            end
            ST_WAIT_ECHO: begin
                if (echo_s_q)       state_d = ST_MEASURE;
                else if (wait_to_c) state_d = ST_HOLDOFF;
            end
            ST_MEASURE: begin
                if (done_c) state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if ((period_q == '0) && !echo_s_q) state_d = ST_TRIGGER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, result capture and presence filter
    always_comb begin
        period_d     = (period_q != '0) ? period_q - 32'd1 : '0;
        trig_cnt_d   = trig_cnt_q;
        width_d      = width_q;
        echo_width_d = echo_width_q;
        near_run_d   = near_run_q;
        far_run_d    = far_run_q;
        presence_d   = presence_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;
        trigger_d    = (state_d == ST_TRIGGER);

        case (state_q)
            ST_TRIGGER: begin
                trig_cnt_d = trig_cnt_q + 32'd1;
                width_d    = '0;
            end
            ST_WAIT_ECHO: begin
                width_d = echo_s_q ? 32'd1 : width_q + 32'd1;
            end
            ST_MEASURE: begin
                if (meas_to_c)     width_d = ECHO_TIMEOUT;
                else if (echo_s_q) width_d = width_q + 32'd1;
            end
            default: ;
        endcase

        // Period and pulse counters restart on every entry to TRIGGER
        if ((state_d == ST_TRIGGER) && (state_q != ST_TRIGGER)) begin
            period_d   = PERIOD_CYCLES - 32'd1;
            trig_cnt_d = '0;
        end

        if (done_c) begin
            valid_d      = 1'b1;
            timeout_d    = !meas_ok_c;
            echo_width_d = meas_ok_c ? width_q : ECHO_TIMEOUT;
            if (near_c) begin
                near_run_d = (near_run_q == 2'd3) ? 2'd3 : near_run_q + 2'd1;
                far_run_d  = '0;
                if (near_run_d == CONFIRM_COUNT) presence_d = 1'b1;
            end else begin
                far_run_d  = (far_run_q == 2'd3) ? 2'd3 : far_run_q + 2'd1;
                near_run_d = '0;
                if (far_run_d == RELEASE_COUNT) presence_d = 1'b0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            period_q     <= '0;
            trig_cnt_q   <= '0;
            width_q      <= '0;
            echo_width_q <= '0;
            near_run_q   <= '0;
            far_run_q    <= '0;
            trigger_q    <= 1'b0;
            presence_q   <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            period_q     <= period_d;
            trig_cnt_q   <= trig_cnt_d;
            width_q      <= width_d;
            echo_width_q <= echo_width_d;
            near_run_q   <= near_run_d;
            far_run_q    <= far_run_d;
            trigger_q    <= trigger_d;
            presence_q   <= presence_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign out_trigger         = trigger_q;
    assign out_presence_signal = presence_q;
    assign out_echo_width      = echo_width_q;
    assign out_measure_valid   = valid_q;
    assign out_timeout_error   = timeout_q;

endmodule
